// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing helper for serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(WIDTH/DIGIT), never less than one bit.
  function automatic int cnt_width(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// fa: one-bit full adder, the cell of the per-cycle ripple chain.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands DIGIT bits per clock through a
// DIGIT-long full-adder chain and a carry register, with start/busy/done
// handshake and registered sum, carry-out and signed overflow.
// Optional feature macro: SERIAL_ADDER_SUB_EN (honour i_sub for a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_dsum;
  logic [WIDTH-1:0] w_psum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Operand B and carry-in as loaded on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = i_sub ? ~i_b : i_b;
  assign w_c_load = i_sub ? 1'b1 : i_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = i_sub;
  assign w_b_load     = i_b;
  assign w_c_load     = i_cin;
`endif

  // Ripple chain: the only combinational arithmetic in the block.
  assign w_c[0] = r_carry;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_chain
    fa u_fa (
      .a    (r_a[gi]),
      .b    (r_b[gi]),
      .cin  (w_c[gi]),
      .s    (w_dsum[gi]),
      .cout (w_c[gi+1])
    );
  end

  // Partial sum: new digits enter at the top; only completed digits are stored.
  if (N == 1) begin : g_psum_single
    assign w_psum_next = w_dsum;
  end else begin : g_psum_shift
    logic [WIDTH-DIGIT-1:0] r_psum;
    assign w_psum_next = {w_dsum, r_psum};

    // Shift the finished digits down while running.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_psum <= '0;
      end else if (r_state == RUN) begin
        r_psum <= w_psum_next[WIDTH-1:DIGIT];
      end
    end
  end

  // Control FSM plus operand/carry/counter registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_psum_next;
            r_cout  <= w_c[DIGIT];
            r_ovf   <= w_c[DIGIT-1] ^ w_c[DIGIT];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, clocked successor to the combinational 4-bit ripple adder. It adds two WIDTH-bit operands DIGIT bits per clock, using a chain of DIGIT one-bit full adders and a carry register. It exposes a start/busy/done handshake, a registered result, carry-out and signed overflow. It serves board-level arithmetic labs and any datapath that trades latency for adder area.

## Interface
- WIDTH, default 4: operand and result width; must be ≥ 2.
- DIGIT, default 1: bits processed per clock; must divide WIDTH exactly; N = WIDTH/DIGIT.
- Clock  in  1: the single clock; all logic on the rising edge.
- Reset  in  1: synchronous, active-high reset.
- start  in  1: request; sampled only in IDLE or DONE.
- a  in  WIDTH: operand A; captured on the accepted start.
- b  in  WIDTH: operand B; captured on the accepted start.
- cin  in  1: carry-in; captured on the accepted start.
- sub  in  1: subtract request; captured on the accepted start (see Configuration).
- busy  out  1: high while in RUN.
- done  out  1: one-cycle pulse when the result registers update.
- sum  out  WIDTH: registered result.
- cout  out  1: registered carry-out of the MSB.
- ovf  out  1: registered signed overflow, equal to carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
- IDLE:
  - When start=1, load the A shift register with a.
  - Load the B shift register with b, or with ~b when subtracting.
  - Load the carry register with cin, or with 1 when subtracting.
  - Clear the digit counter and go to RUN.
- RUN, every cycle:
  - The low DIGIT bits of A and B plus the carry register pass through the DIGIT-bit full-adder chain.
  - The digit sum shifts into the top of the partial-sum register; A and B shift right by DIGIT.
  - The chain carry-out is written to the carry register.
  - On the N-th digit (counter = N-1):
    - Load sum from the completed partial sum.
    - Load cout from the chain carry-out.
    - Load ovf from the chain carry-in of the MSB XOR the chain carry-out.
    - Go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - If start=1, accept new operands and go to RUN (back-to-back operation). Otherwise go to IDLE.
- start in RUN is ignored; it is neither queued nor does it abort.
- sum, cout and ovf change only at the completion edge. They hold through DONE and IDLE until the next completion.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry (for subtraction, cout=1 means no borrow).

## Timing
- Reset value of every output is 0: busy=0, done=0, sum=0, cout=0, ovf=0. The internal shift, carry and counter registers also clear to 0.
- If start is accepted at edge k:
  - busy is high for the cycles following edges k through k+N-1.
  - Results are valid after edge k+N, with done high in that same cycle.
  - Latency is N+1 cycles from start sampled to done observed.
- Back-to-back throughput is one result every N+1 cycles.
- Reset asserted mid-RUN aborts the operation on that edge:
  - Go to IDLE.
  - All outputs go to 0.
  - No done pulse.
  - The previous result is discarded.
- Reset and start asserted in the same cycle: Reset wins.

## Configuration
- SERIAL_ADDER_SUB_EN defined: the sub input is honoured. With sub=1 the block computes a − b by inverting b and forcing carry-in to 1; cin is ignored.
- SERIAL_ADDER_SUB_EN undefined:
  - The sub port remains on the interface but is ignored.
  - B is never inverted and the carry-in is always cin.
  - The inversion mux is not synthesised.

## Structure
- Package serial_adder_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - a function returning the counter width, clog2(WIDTH/DIGIT) with a minimum of 1.
- Sub-module: the existing one-bit full adder fa (inputs a, b, cin; outputs s, cout), instantiated DIGIT times via generate as the per-cycle ripple chain.
- All registers live in the top module. The chain is the only combinational arithmetic.

## Test plan
- WIDTH=4, DIGIT=1: a=7, b=5, cin=0 → after 5 cycles done=1, sum=12, cout=0, ovf=1; busy high for exactly 4 cycles.
- WIDTH=4: a=15, b=1, cin=0 → sum=0, cout=1, ovf=0. Then a=15, b=0, cin=1 → sum=0, cout=1, ovf=0.
- WIDTH=8, DIGIT=2: a=0x7F, b=0x01 → done 5 cycles after start, sum=0x80, cout=0, ovf=1. A start pulse during RUN is ignored, and exactly one done is produced.
- SERIAL_ADDER_SUB_EN defined, WIDTH=4, sub=1: a=3, b=5 → sum=14, cout=0, ovf=0. a=5, b=3 → sum=2, cout=1.
- Reset asserted in the second RUN cycle → next cycle busy=0, done=0, and sum/cout/ovf=0. No done pulse follows.
- start held high across DONE → a new operation starts immediately. Two consecutive done pulses are N+1 cycles apart, each with the correct result.
